// File: rtl/leg_decode_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : leg_decode_stage
// Purpose  : Buffered instruction-decode stage for the LEG core. Assembles
//            4-byte instructions (opcode, arg1, arg2, dest) from a byte-wide
//            fetch stream, decodes the opcode and queues the result in an
//            OUT_DEPTH-entry FIFO with a valid/ready output handshake.
// Ports    : clk, rst (async, active-low), flush (sync discard)
//            in_valid / in_byte / in_ready      : fetch byte stream
//            out_valid / out_ready              : decoded instruction handshake
//            out_imm1, out_imm2, out_calc, out_jump, out_cond, out_alu_op,
//            out_illegal, out_arg1, out_arg2, out_dest : FIFO head fields
// Revision : 1.0 - initial release
// ============================================================================
module leg_decode_stage #(
    parameter logic [7:0] JUMP_BASE = 8'h20,
    parameter int         NUM_COND  = 10,
    parameter int         OUT_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_imm1,
    output logic       out_imm2,
    output logic       out_calc,
    output logic       out_jump,
    output logic [3:0] out_cond,
    output logic [3:0] out_alu_op,
    output logic       out_illegal,
    output logic [7:0] out_arg1,
    output logic [7:0] out_arg2,
    output logic [7:0] out_dest
);

    localparam int c_PTR_W   = $clog2(OUT_DEPTH);
    localparam int c_CNT_W   = $clog2(OUT_DEPTH) + 1;
    localparam int c_ENTRY_W = 37;

    localparam logic [1:0] c_ST_OP  = 2'd0;
    localparam logic [1:0] c_ST_A1  = 2'd1;
    localparam logic [1:0] c_ST_A2  = 2'd2;
    localparam logic [1:0] c_ST_DST = 2'd3;

    // Jump range bounds carried in 7 bits so the upper bound cannot wrap.
    localparam logic [6:0]         c_JUMP_LO = {1'b0, JUMP_BASE[5:0]};
    localparam logic [6:0]         c_JUMP_HI = c_JUMP_LO + 7'(NUM_COND - 1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(OUT_DEPTH);

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [7:0]           r_opcode;
    logic [7:0]           r_arg1;
    logic [7:0]           r_arg2;
    logic [c_ENTRY_W-1:0] r_mem [OUT_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_full;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_calc;
    logic                 w_jump;
    logic [3:0]           w_cond;
    logic [3:0]           w_alu_op;
    logic                 w_illegal;
    logic [6:0]           w_op7;
    logic [c_ENTRY_W-1:0] w_entry;
    logic [c_ENTRY_W-1:0] w_head;

    assign w_full   = (r_count == c_FULL);
    assign w_accept = in_valid & in_ready;
    // Flush wins over any same-cycle transfer on either side.
    assign w_push   = w_accept & (r_state == c_ST_DST) & ~flush;
    assign w_pop    = out_valid & out_ready & ~flush;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_OP;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = c_ST_OP;
        end else if (w_accept) begin
            case (r_state)
                c_ST_OP:  w_next_state = c_ST_A1;
                c_ST_A1:  w_next_state = c_ST_A2;
                c_ST_A2:  w_next_state = c_ST_DST;
                default:  w_next_state = c_ST_OP;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // No pass-through when full: the dest byte waits even if the head pops.
    always_comb begin
        in_ready = rst & ~((r_state == c_ST_DST) & w_full);
    end

    // ---------------- operand latches ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_opcode <= '0;
            r_arg1   <= '0;
            r_arg2   <= '0;
        end else if (w_accept && !flush) begin
            case (r_state)
                c_ST_OP: r_opcode <= in_byte;
                c_ST_A1: r_arg1   <= in_byte;
                c_ST_A2: r_arg2   <= in_byte;
                default: ;
            endcase
        end
    end

    // ---------------- opcode decode ----------------
    // Bits 7:6 are the immediate flags and take no part in calc/jump matching.
    assign w_op7     = {1'b0, r_opcode[5:0]};
    assign w_calc    = (r_opcode[5:4] == 2'b00);
    assign w_jump    = (w_op7 >= c_JUMP_LO) && (w_op7 <= c_JUMP_HI);
    assign w_cond    = w_jump ? 4'(w_op7 - c_JUMP_LO) : 4'd0;
    assign w_alu_op  = w_calc ? r_opcode[3:0] : 4'd0;
    assign w_illegal = ~w_calc & ~w_jump;

    assign w_entry = {r_opcode[7], r_opcode[6], w_calc, w_jump, w_cond,
                      w_alu_op, w_illegal, r_arg1, r_arg2, in_byte};

    // ---------------- output FIFO ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = (r_count != '0);

    assign {out_imm1, out_imm2, out_calc, out_jump, out_cond, out_alu_op,
            out_illegal, out_arg1, out_arg2, out_dest} = w_head;

endmodule
`default_nettype wire

// File: tb/tb_leg_decode_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_leg_decode_stage
// Purpose  : Self-checking bench for leg_decode_stage (default parameters).
//            Expected decodes are queued when instructions are driven and
//            popped when the stage presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_leg_decode_stage;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       flush     = 1'b0;
    logic       in_valid  = 1'b0;
    logic [7:0] in_byte   = 8'h00;
    logic       out_ready = 1'b0;

    logic       in_ready;
    logic       out_valid;
    logic       out_imm1;
    logic       out_imm2;
    logic       out_calc;
    logic       out_jump;
    logic [3:0] out_cond;
    logic [3:0] out_alu_op;
    logic       out_illegal;
    logic [7:0] out_arg1;
    logic [7:0] out_arg2;
    logic [7:0] out_dest;

    int n_vec = 0;
    int n_err = 0;

    logic [36:0] exp_q[$];
    logic [36:0] obs;

    assign obs = {out_imm1, out_imm2, out_calc, out_jump, out_cond, out_alu_op,
                  out_illegal, out_arg1, out_arg2, out_dest};

    leg_decode_stage #(
        .JUMP_BASE (8'h20),
        .NUM_COND  (10),
        .OUT_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_byte     (in_byte),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm1    (out_imm1),
        .out_imm2    (out_imm2),
        .out_calc    (out_calc),
        .out_jump    (out_jump),
        .out_cond    (out_cond),
        .out_alu_op  (out_alu_op),
        .out_illegal (out_illegal),
        .out_arg1    (out_arg1),
        .out_arg2    (out_arg2),
        .out_dest    (out_dest)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference decode for JUMP_BASE=6'h20, NUM_COND=10 (jump opcodes 20..29).
    function automatic logic [36:0] model(input logic [7:0] op, input logic [7:0] a1,
                                          input logic [7:0] a2, input logic [7:0] d);
        logic [5:0] o6;
        logic       calc;
        logic       jump;
        logic [3:0] cond;
        logic [3:0] alu;
        o6   = op[5:0];
        calc = (o6 < 6'h10);
        jump = (o6 >= 6'h20) && (o6 <= 6'h29);
        cond = jump ? 4'(o6 - 6'h20) : 4'h0;
        alu  = calc ? op[3:0] : 4'h0;
        return {op[7], op[6], calc, jump, cond, alu, ~calc & ~jump, a1, a2, d};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL send_byte_timeout byte=%h in_ready=%b required=1", b, in_ready);
        end
    endtask

    task automatic send_instr(input logic [7:0] op, input logic [7:0] a1,
                              input logic [7:0] a2, input logic [7:0] d);
        send_byte(op);
        send_byte(a1);
        send_byte(a2);
        send_byte(d);
    endtask

    // Pops n decoded instructions and compares each against the scoreboard.
    task automatic drain(input int n, input string tag);
        bit          got;
        logic [36:0] e;
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            got = 1'b0;
            for (int i = 0; i < 60 && !got; i++) begin
                @(negedge clk);
                if (out_valid === 1'b1) got = 1'b1;
            end
            n_vec++;
            if (!got) begin
                n_err++;
                $display("FAIL %s_timeout[%0d] out_valid=%b required=1", tag, k, out_valid);
            end else if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL %s_unexpected[%0d] got=%h required=nothing", tag, k, obs);
                @(posedge clk);
                #1;
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    n_err++;
                    $display("FAIL %s[%0d] got=%h required=%h", tag, k, obs, e);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_ready got=%b required=0", in_ready);
        end
        n_vec++;
        if ({out_valid, obs} !== 38'h0) begin
            n_err++;
            $display("FAIL reset_outputs got=%b_%h required=0_0", out_valid, obs);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset got in_ready=%b out_valid=%b required in_ready=1 out_valid=0",
                     in_ready, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_decode();
        logic [7:0]  ops [7] = '{8'h05, 8'hC3, 8'h29, 8'h2A, 8'hA0, 8'h4F, 8'h1F};
        logic [7:0]  a1s [7] = '{8'h11, 8'h07, 8'h01, 8'h04, 8'hAA, 8'h00, 8'h12};
        logic [7:0]  a2s [7] = '{8'h22, 8'h08, 8'h02, 8'h05, 8'hBB, 8'hFF, 8'h34};
        logic [7:0]  ds  [7] = '{8'h33, 8'h09, 8'h03, 8'h06, 8'hCC, 8'h80, 8'h56};
        logic [36:0] exps[7] = '{
            {1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h5, 1'b0, 8'h11, 8'h22, 8'h33},
            {1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h3, 1'b0, 8'h07, 8'h08, 8'h09},
            {1'b0, 1'b0, 1'b0, 1'b1, 4'h9, 4'h0, 1'b0, 8'h01, 8'h02, 8'h03},
            {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 8'h04, 8'h05, 8'h06},
            {1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 8'hAA, 8'hBB, 8'hCC},
            {1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 8'h00, 8'hFF, 8'h80},
            {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 8'h12, 8'h34, 8'h56}};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(exps[i]);
            send_instr(ops[i], a1s[i], a2s[i], ds[i]);
            #1;
            n_vec++;
            if (out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL decode_latency[%0d] out_valid=%b required=1", i, out_valid);
            end
            drain(1, "decode");
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [24];
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 4; j++) b[i*4+j] = 8'($urandom);
            exp_q.push_back(model(b[i*4], b[i*4+1], b[i*4+2], b[i*4+3]));
        end
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 24; i++) send_byte(b[i]);
            end
            drain(6, "back_to_back");
        join
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        exp_q.push_back(model(8'h01, 8'h10, 8'h20, 8'h30));
        exp_q.push_back(model(8'h22, 8'h11, 8'h21, 8'h31));
        exp_q.push_back(model(8'hEA, 8'h12, 8'h22, 8'h32));
        send_instr(8'h01, 8'h10, 8'h20, 8'h30);
        send_instr(8'h22, 8'h11, 8'h21, 8'h31);
        send_byte(8'hEA);
        send_byte(8'h12);
        send_byte(8'h22);
        in_valid = 1'b1;
        in_byte  = 8'h32;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_in_ready[%0d] got=%b required=0", i, in_ready);
            end
            n_vec++;
            if (out_valid !== 1'b1 || obs !== exp_q[0]) begin
                n_err++;
                $display("FAIL stall_head_hold[%0d] got=%b_%h required=1_%h", i, out_valid, obs, exp_q[0]);
            end
        end
        @(posedge clk);
        #1;
        fork
            send_byte(8'h32);
            drain(3, "stall_release");
        join
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send_instr(8'h03, 8'h44, 8'h55, 8'h66);
        send_byte(8'h21);
        send_byte(8'h77);
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL flush_pre_queued out_valid=%b required=1", out_valid);
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h99;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_out_valid got=%b required=0", out_valid);
        end
        exp_q.push_back(model(8'h87, 8'h9A, 8'hBC, 8'hDE));
        send_instr(8'h87, 8'h9A, 8'hBC, 8'hDE);
        drain(1, "post_flush");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send_instr(8'h0C, 8'h01, 8'h02, 8'h03);
        send_byte(8'h25);
        send_byte(8'h5A);
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_in_ready got=%b required=0", in_ready);
        end
        n_vec++;
        if ({out_valid, obs} !== 38'h0) begin
            n_err++;
            $display("FAIL midreset_outputs got=%b_%h required=0_0", out_valid, obs);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.push_back(model(8'h28, 8'hF0, 8'h0F, 8'h5A));
        send_instr(8'h28, 8'hF0, 8'h0F, 8'h5A);
        drain(1, "post_midreset");
    endtask

    task automatic test_push_pop();
        logic [36:0] e;
        out_ready = 1'b0;
        exp_q.push_back(model(8'h09, 8'hA1, 8'hA2, 8'hA3));
        exp_q.push_back(model(8'h6B, 8'hB1, 8'hB2, 8'hB3));
        send_instr(8'h09, 8'hA1, 8'hA2, 8'hA3);
        send_byte(8'h6B);
        send_byte(8'hB1);
        send_byte(8'hB2);
        in_valid  = 1'b1;
        in_byte   = 8'hB3;
        out_ready = 1'b1;
        @(negedge clk);
        e = exp_q.pop_front();
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || obs !== e) begin
            n_err++;
            $display("FAIL pushpop_before got=%b%b_%h required=11_%h", in_ready, out_valid, obs, e);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        n_vec++;
        if (out_valid !== 1'b1 || obs !== e) begin
            n_err++;
            $display("FAIL pushpop_head got=%b_%h required=1_%h", out_valid, obs, e);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL pushpop_occupancy out_valid=%b required=0 after single pop", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid();
        test_push_pop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
